// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises board reset and PLL lock, enforces a hold
// time, then releases NUM_OUT active-low resets in order with a fixed gap.
// Ports:
//   clk           - system clock
//   async_rst_n   - async active-low reset, release synchronised internally
//   pll_locked    - async PLL lock indication
//   sw_rst_req    - single-cycle software reset request (clk domain)
//   sync_rst_n    - sequenced active-low resets, bit 0 released first
//   rst_done      - all outputs released
//   lock_loss_cnt - saturating count of lock losses seen in RUN
// Optional: define RST_SEQ_SW_RST_EN to make sw_rst_req abort the sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] sync_rst_n,
    output logic               rst_done,
    output logic [7:0]         lock_loss_cnt
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES
                                                    : GAP_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]      GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_s;
    logic                   lock_s;
    logic                   ok;
    logic                   sw_abort;
    logic                   abort;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_OUT-1:0]   rst_q, rst_d;
    logic                 done_q, done_d;
    logic [7:0]           llc_q, llc_d;

`ifdef RST_SEQ_SW_RST_EN
    assign sw_abort = sw_rst_req;
`else
    logic unused_sw;
    assign unused_sw = sw_rst_req;
    assign sw_abort  = 1'b0;
`endif

    // Reset chain shifts in a constant 1; lock chain samples pll_locked.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign rst_s  = rst_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign ok     = rst_s & lock_s;
    assign abort  = !ok || sw_abort;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            llc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            llc_q   <= llc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        llc_d   = llc_q;

        unique case (state_q)
            ST_ASSERT: begin
                rst_d  = '0;
                done_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (ok) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    rst_d[0] = 1'b1;
                    cnt_d    = '0;
                    if (NUM_OUT == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    rst_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    rst_d = rst_q | (ONE << idx_q);
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                // Lock loss counts even when a sw request coincides.
                if (!lock_s && llc_q != 8'hFF) begin
                    llc_d = llc_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    assign sync_rst_n    = rst_q;
    assign rst_done      = done_q;
    assign lock_loss_cnt = llc_q;

endmodule
